// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the decode stage and the hazard scoreboard.
// The master drives the ID-stage instruction and flush; the slave returns stall and forwarding selects.
interface hazard_scoreboard_if #(
    parameter int AW = 5,
    parameter int LW = 2,
    parameter int SW = 2,
    parameter int CW = 16
);
    logic          issue_valid;
    logic [AW-1:0] issue_rs1;
    logic [AW-1:0] issue_rs2;
    logic          issue_rs1_used;
    logic          issue_rs2_used;
    logic          issue_we;
    logic [AW-1:0] issue_rd;
    logic [LW-1:0] issue_lat;
    logic          flush;
    logic          stall;
    logic [SW-1:0] fwd_a;
    logic [SW-1:0] fwd_b;
    logic [CW-1:0] stall_cycles;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
        output issue_we, issue_rd, issue_lat, flush,
        input  stall, fwd_a, fwd_b, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
        input  issue_we, issue_rd, issue_lat, flush,
        output stall, fwd_a, fwd_b, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard tracking in-flight writers: raises stall on unresolved RAW hazards
// and selects the forwarding stage once a producer's result is available.
module hazard_scoreboard #(
    parameter int NREG      = 32,
    parameter int DEPTH     = 3,
    parameter int MAX_LAT   = 2,
    parameter int FLUSH_AGE = 1,
    parameter int CW        = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(MAX_LAT + 1);

    logic [NREG-1:0] busy_q, busy_d;
    logic [SW-1:0]   age_q [NREG];
    logic [SW-1:0]   age_d [NREG];
    logic [LW-1:0]   rem_q [NREG];
    logic [LW-1:0]   rem_d [NREG];
    logic [CW-1:0]   stall_cycles_q, stall_cycles_d;

    logic          haz_a, haz_b, ready_a, ready_b;
    logic          stall, accept;
    logic [LW-1:0] lat_clamped, rem_new;

    // A source is ready to forward once its producer's remaining latency has reached zero.
    always_comb begin
        haz_a   = sb.issue_rs1_used && (sb.issue_rs1 != '0) && busy_q[sb.issue_rs1]
                  && (rem_q[sb.issue_rs1] != '0);
        haz_b   = sb.issue_rs2_used && (sb.issue_rs2 != '0) && busy_q[sb.issue_rs2]
                  && (rem_q[sb.issue_rs2] != '0);
        ready_a = sb.issue_rs1_used && (sb.issue_rs1 != '0) && busy_q[sb.issue_rs1]
                  && (rem_q[sb.issue_rs1] == '0);
        ready_b = sb.issue_rs2_used && (sb.issue_rs2 != '0) && busy_q[sb.issue_rs2]
                  && (rem_q[sb.issue_rs2] == '0);
        stall   = sb.issue_valid && (haz_a || haz_b) && !sb.flush;
        accept  = sb.issue_valid && !stall && !sb.flush;
    end

    assign sb.stall        = stall;
    assign sb.fwd_a        = ready_a ? age_q[sb.issue_rs1] : '0;
    assign sb.fwd_b        = ready_b ? age_q[sb.issue_rs2] : '0;
    assign sb.stall_cycles = stall_cycles_q;

    always_comb begin
        lat_clamped = (sb.issue_lat > LW'(MAX_LAT)) ? LW'(MAX_LAT) : sb.issue_lat;
        rem_new     = (lat_clamped == '0) ? '0 : lat_clamped - LW'(1);
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned and infers a latch.
        busy_d = busy_q;
        age_d  = age_q;
        rem_d  = rem_q;
        for (int r = 1; r < NREG; r++) begin
            if (busy_q[r]) begin
                if ((sb.flush && (age_q[r] <= SW'(FLUSH_AGE))) || (age_q[r] == SW'(DEPTH))) begin
                    busy_d[r] = 1'b0;
                    age_d[r]  = '0;
                    rem_d[r]  = '0;
                end else begin
                    age_d[r] = age_q[r] + SW'(1);
                    rem_d[r] = (rem_q[r] == '0) ? '0 : rem_q[r] - LW'(1);
                end
            end
        end
        // The youngest writer replaces whatever the older entry for rd was doing this cycle.
        if (accept && sb.issue_we && (sb.issue_rd != '0)) begin
            busy_d[sb.issue_rd] = 1'b1;
            age_d[sb.issue_rd]  = SW'(1);
            rem_d[sb.issue_rd]  = rem_new;
        end
        busy_d[0] = 1'b0;

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q         <= '0;
            stall_cycles_q <= '0;
            // NOTE: the age/rem arrays are reset too, so no stale entry can outlive a reset.
            for (int r = 0; r < NREG; r++) begin
                age_q[r] <= '0;
                rem_q[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            busy_q         <= busy_d;
            age_q          <= age_d;
            rem_q          <= rem_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
  NREG, 32, architectural registers tracked; AW = clog2(NREG)
  DEPTH, 3, forwarding stages after ID (1=EX/MEM, 2=MEM/WB, 3=WB bypass); SW = clog2(DEPTH+1)
  MAX_LAT, 2, largest producer latency; LW = clog2(MAX_LAT+1); MAX_LAT <= DEPTH
  FLUSH_AGE, 1, entries with age <= FLUSH_AGE are killed by flush
  CW, 16, stall-cycle counter width
REQ-002 Ports SHALL be, one per line, name direction width meaning:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-high reset
  issue_valid  in  1  instruction in ID presented for issue
  issue_rs1 / issue_rs2  in  AW  source registers
  issue_rs1_used / issue_rs2_used  in  1  source actually read
  issue_we  in  1  instruction writes rd
  issue_rd  in  AW  destination register
  issue_lat  in  LW  cycles after issue until result is forwardable
  flush  in  1  branch/jump redirect from EX
  stall  out  1  hold PC and IF/ID, bubble ID/EX
  fwd_a / fwd_b  out  SW  0 = register file, k = forward from stage k
  stall_cycles  out  CW  saturating count of stalled cycles

Function
REQ-003 Block SHALL keep, per register r in 1..NREG-1, busy[r], age[r] (SW bits), rem[r] (LW bits); register 0 SHALL never be busy.
REQ-004 Source s SHALL hazard when s_used & s!=0 & busy[s] & rem[s]!=0.
REQ-005 stall SHALL equal issue_valid & (hazard on rs1 | hazard on rs2) & ~flush, combinationally from current state and inputs.
REQ-006 fwd_a SHALL equal age[rs1] when issue_rs1_used & rs1!=0 & busy[rs1] & rem[rs1]==0, else 0; fwd_b likewise for rs2.
REQ-007 Issue SHALL be accepted when issue_valid & ~stall & ~flush.
REQ-008 On accepted issue with issue_we & rd!=0: next busy[rd]=1, age[rd]=1, rem[rd]=max(issue_lat,1)-1, with issue_lat > MAX_LAT clamped to MAX_LAT.
REQ-009 Each cycle every other busy entry SHALL advance: age+1, rem decremented saturating at 0; an entry with age==DEPTH SHALL clear busy instead of advancing.
REQ-010 Same-register events: a new accepted issue on rd SHALL override aging/retirement of rd in that cycle (youngest writer wins).
REQ-011 flush SHALL block that cycle's issue and clear busy for every entry with age <= FLUSH_AGE before aging; older entries age normally.
REQ-012 stall_cycles SHALL increment by 1 each cycle stall==1, saturating at 2^CW-1.
REQ-013 While stalled, table SHALL continue aging so the stall resolves without further input change.
REQ-014 Latency: a consumer issued the cycle after an issue_lat=1 producer SHALL see stall=0, fwd=1; issue_lat=L SHALL cause exactly L-1 stall cycles for an immediate consumer.

Reset
REQ-015 rst SHALL asynchronously clear all busy, age, rem and stall_cycles; stall, fwd_a, fwd_b SHALL read 0 while rst is high and on the first cycle after release.
REQ-016 rst asserted mid-operation SHALL discard all in-flight entries; no entry survives reset.

Verification (DEPTH=3, MAX_LAT=2, FLUSH_AGE=1)
REQ-017 ALU chain: issue rd=5 lat=1; next cycle rs1=5 used -> stall=0, fwd_a=1; one cycle later rs1=5 -> fwd_a=2; one later -> fwd_a=3; one later -> fwd_a=0.
REQ-018 Load-use: issue rd=7 lat=2; next cycle rs2=7 used -> stall=1, fwd_b=0, stall_cycles=1 after edge; following cycle stall=0, fwd_b=2.
REQ-019 x0: issue rd=0 we=1; next cycle rs1=0, rs2=0 used -> stall=0, fwd_a=fwd_b=0.
REQ-020 Youngest wins: issue rd=3 lat=1 two consecutive cycles; third cycle rs1=3 -> fwd_a=1.
REQ-021 Flush: issue rd=9 lat=2; next cycle flush=1 with issue_valid rd=4 -> both cancelled; next cycle rs1=9, rs2=4 used -> stall=0, fwd_a=fwd_b=0.
REQ-022 Reset mid-op: with rd=7 lat=2 pending and stall=1, assert rst between edges -> stall=0, fwd=0, stall_cycles=0 immediately; after release rs1=7 -> fwd_a=0.
